// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin AR arbiter sharing one AXI read port among NREQ readers
// ARID carries the requester index; R beats are routed back by RID with per-requester burst limits.
module axi_rd_arbiter #(
  parameter int         NREQ    = 3,
  parameter int         MAX_OUT = 4,
  parameter logic [2:0] ARSIZE  = 3'b110
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ*64-1:0] req_araddr,
  input  logic [NREQ*8-1:0]  req_arlen,
  input  logic [NREQ-1:0]    req_arvalid,
  output logic [NREQ-1:0]    req_arready,
  output logic [511:0]       resp_rdata,
  output logic               resp_rlast,
  output logic [NREQ-1:0]    resp_rvalid,
  input  logic [NREQ-1:0]    resp_rready,
  output logic [15:0]        arid_m,
  output logic [63:0]        araddr_m,
  output logic [7:0]         arlen_m,
  output logic [2:0]         arsize_m,
  output logic               arvalid_m,
  input  logic               arready_m,
  input  logic [15:0]        rid_m,
  input  logic [511:0]       rdata_m,
  input  logic [1:0]         rresp_m,
  input  logic               rlast_m,
  input  logic               rvalid_m,
  output logic               rready_m,
  output logic [NREQ*4-1:0]  outstanding,
  output logic               err
);

  localparam int         IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [63:0]     r_addr;
  logic [7:0]      r_len;
  logic [3:0]      r_cnt [NREQ];
  logic            r_err;

  logic [NREQ-1:0] w_elig;
  logic            w_grant;
  logic [IW-1:0]   w_win;
  logic [63:0]     w_sel_addr;
  logic [7:0]      w_sel_len;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic [NREQ-1:0] w_inc;
  logic [NREQ-1:0] w_dec;
  logic            w_err_set;

  // Indices above the pointer outrank those at or below it; the second pass overrides the first.
  always_comb begin
    w_elig  = '0;
    w_grant = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_arvalid[i] && (r_cnt[i] < CNT_MAX);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (i <= int'(r_ptr))) begin
        w_grant = 1'b1;
        w_win   = IW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (i > int'(r_ptr))) begin
        w_grant = 1'b1;
        w_win   = IW'(i);
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_sel_addr = req_araddr[64*i +: 64];
        w_sel_len  = req_arlen[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NREQ - 1);
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && w_grant) begin
        r_ptr  <= w_win;
        r_id   <= w_win;
        r_addr <= w_sel_addr;
        r_len  <= w_sel_len;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)   w_next_state = S_ISSUE;
      S_ISSUE: if (arready_m) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_arready = '0;
    arvalid_m   = 1'b0;
    case (r_state)
      S_IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          req_arready[i] = w_grant && (w_win == IW'(i));
        end
      end
      S_ISSUE: arvalid_m = 1'b1;
      default: arvalid_m = 1'b0;
    endcase
  end

  assign arid_m   = 16'(r_id);
  assign araddr_m = r_addr;
  assign arlen_m  = r_len;
  assign arsize_m = ARSIZE;

  // Beats with an RID outside the requester range are accepted and discarded.
  always_comb begin
    rready_m    = 1'b1;
    resp_rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rid_m == 16'(i)) begin
        rready_m       = resp_rready[i];
        resp_rvalid[i] = rvalid_m;
      end
    end
  end

  assign resp_rdata = rdata_m;
  assign resp_rlast = rlast_m;
  assign w_ar_hs    = (r_state == S_ISSUE) && arready_m;
  assign w_r_hs     = rvalid_m && rready_m;

  always_comb begin
    w_err_set = w_r_hs && ((rid_m >= 16'(NREQ)) || (rresp_m != 2'b00));
    w_inc     = '0;
    w_dec     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_inc[i] = w_ar_hs && (r_id == IW'(i));
      w_dec[i] = w_r_hs && rlast_m && (rid_m == 16'(i));
      if (w_dec[i] && !w_inc[i] && (r_cnt[i] == 4'd0)) begin
        w_err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 4'd0)) begin
          r_cnt[i] <= r_cnt[i] - 4'd1;
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NREQ; i++) begin
      outstanding[4*i +: 4] = r_cnt[i];
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard testbench for axi_rd_arbiter
// Randomized requesters and memory; expected ARs and R beats are queued and popped by monitors.
module tb_axi_rd_arbiter;

  localparam int NREQ    = 3;
  localparam int MAX_OUT = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ*64-1:0] req_araddr = '0;
  logic [NREQ*8-1:0]  req_arlen = '0;
  logic [NREQ-1:0]    req_arvalid = '0;
  logic [NREQ-1:0]    req_arready;
  logic [511:0]       resp_rdata;
  logic               resp_rlast;
  logic [NREQ-1:0]    resp_rvalid;
  logic [NREQ-1:0]    resp_rready = '0;
  logic [15:0]        arid_m;
  logic [63:0]        araddr_m;
  logic [7:0]         arlen_m;
  logic [2:0]         arsize_m;
  logic               arvalid_m;
  logic               arready_m = 1'b0;
  logic [15:0]        rid_m = '0;
  logic [511:0]       rdata_m = '0;
  logic [1:0]         rresp_m = '0;
  logic               rlast_m = 1'b0;
  logic               rvalid_m = 1'b0;
  logic               rready_m;
  logic [NREQ*4-1:0]  outstanding;
  logic               err;

  axi_rd_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .ARSIZE(3'b110)) dut (
    .clk(clk), .rst(rst),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
    .req_arready(req_arready),
    .resp_rdata(resp_rdata), .resp_rlast(resp_rlast), .resp_rvalid(resp_rvalid),
    .resp_rready(resp_rready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [71:0]  rq     [NREQ][$];
  logic [79:0]  exp_ar [$];
  logic [512:0] exp_r  [NREQ][$];
  logic [17:0]  mem_q  [$];

  bit          m_busy;
  int          m_id;
  int          m_ptr;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int          m_cnt [NREQ];
  bit          m_err;
  bit          hs;

  bit          cur_valid;
  int          cur_id;
  int          cur_left;
  logic [1:0]  cur_resp;
  logic [1:0]  force_resp;
  bit          mem_en;
  int          req_pct, arready_pct, rvalid_pct, rready_pct;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    int win;
    int rid;
    int inc;
    int dec;
    logic exp_rr;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    if (rst) begin
      m_busy = 0;
      m_ptr  = NREQ - 1;
      m_err  = 0;
      hs     = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      chk("rst_arvalid", arvalid_m, 0);
      chk("rst_arid", arid_m, 0);
      chk("rst_araddr", araddr_m, 0);
      chk("rst_arlen", arlen_m, 0);
      chk("rst_req_arready", req_arready, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 0);
      return;
    end
    win = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (win < 0 && req_arvalid[(m_ptr + k) % NREQ] && m_cnt[(m_ptr + k) % NREQ] < MAX_OUT)
          win = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_arready", req_arready, exp_rdy);
    chk("arvalid_m", arvalid_m, m_busy);
    if (m_busy) begin
      chk("arid_hold", arid_m, 16'(m_id));
      chk("araddr_hold", araddr_m, m_addr);
      chk("arlen_hold", arlen_m, m_len);
    end
    chk("arsize_m", arsize_m, 3'b110);
    rid    = int'(rid_m);
    exp_rr = (rid < NREQ) ? resp_rready[rid] : 1'b1;
    exp_rv = '0;
    if (rvalid_m && rid < NREQ) exp_rv[rid] = 1'b1;
    chk("rready_m", rready_m, exp_rr);
    chk("resp_rvalid", resp_rvalid, exp_rv);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("outstanding%0d", i), outstanding[4*i +: 4], 4'(m_cnt[i]));
    chk("err", err, m_err);

    hs = rvalid_m && exp_rr;
    if (hs && (rid >= NREQ || rresp_m != 2'b00)) m_err = 1;
    inc = (m_busy && arready_m) ? m_id : -1;
    dec = (hs && rlast_m && rid < NREQ) ? rid : -1;
    if (inc >= 0) begin
      mem_q.push_back({2'b00, 8'(m_id), m_len});
      m_busy = 0;
    end
    if (inc != dec) begin
      if (inc >= 0) m_cnt[inc]++;
      if (dec >= 0) begin
        if (m_cnt[dec] == 0) m_err = 1;
        else m_cnt[dec]--;
      end
    end
    if (win >= 0) begin
      m_busy = 1;
      m_id   = win;
      m_ptr  = win;
      m_addr = rq[win][0][63:0];
      m_len  = rq[win][0][71:64];
      exp_ar.push_back({8'(win), m_len, m_addr});
      void'(rq[win].pop_front());
    end
  endtask

  task automatic step();
    logic [17:0] ent;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() < 3 && $urandom_range(99) < req_pct)
        rq[i].push_back({8'($urandom_range(7)), $urandom, $urandom});
      req_arvalid[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        req_araddr[64*i +: 64] = rq[i][0][63:0];
        req_arlen[8*i +: 8]    = rq[i][0][71:64];
      end
      resp_rready[i] = ($urandom_range(99) < rready_pct);
    end
    arready_m = ($urandom_range(99) < arready_pct);
    if (hs) begin
      rvalid_m = 1'b0;
      cur_left--;
      if (cur_left == 0) cur_valid = 0;
    end
    if (!rvalid_m) begin
      if (!cur_valid && mem_en && mem_q.size() != 0) begin
        ent       = mem_q.pop_front();
        cur_valid = 1;
        cur_resp  = ent[17:16];
        cur_id    = int'(ent[15:8]);
        cur_left  = int'(ent[7:0]) + 1;
      end
      if (cur_valid && $urandom_range(99) < rvalid_pct) begin
        rvalid_m = 1'b1;
        rid_m    = 16'(cur_id);
        for (int w = 0; w < 16; w++) rdata_m[32*w +: 32] = $urandom;
        rlast_m  = (cur_left == 1);
        rresp_m  = cur_resp | force_resp;
        if (cur_id < NREQ) exp_r[cur_id].push_back({rlast_m, rdata_m});
      end
    end
    @(negedge clk);
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    rvalid_m    = 1'b0;
    req_arvalid = '0;
    cur_valid   = 0;
    hs          = 0;
    mem_q.delete();
    exp_ar.delete();
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      exp_r[i].delete();
    end
    #1;
    chk("async_arvalid", arvalid_m, 0);
    chk("async_outstanding", outstanding, 0);
    chk("async_err", err, 0);
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    model_eval();
  endtask

  always @(negedge clk) begin
    logic [79:0] e;
    if (!rst && arvalid_m && arready_m) begin
      if (exp_ar.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ar_unexpected actual=id%0d required=none", arid_m);
      end else begin
        e = exp_ar.pop_front();
        chk("ar_id", arid_m, 16'(e[79:72]));
        chk("ar_len", arlen_m, e[71:64]);
        chk("ar_addr", araddr_m, e[63:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [512:0] e;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_rvalid[i] && resp_rready[i]) begin
          if (exp_r[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL r_unexpected actual=beat_for_%0d required=none", i);
          end else begin
            e = exp_r[i].pop_front();
            chk($sformatf("r_data%0d", i), resp_rdata, e[511:0]);
            chk($sformatf("r_last%0d", i), resp_rlast, e[512]);
          end
        end
      end
    end
  end

  initial begin
    req_pct = 0; arready_pct = 100; rvalid_pct = 100; rready_pct = 100;
    mem_en = 1; force_resp = 2'b00;
    do_reset();

    rq[0].push_back({8'd0, 64'h140});
    repeat (8) step();

    // All three requesters loaded while memory stays silent: RR order then MAX_OUT cap
    mem_en = 0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 5; j++)
        rq[i].push_back({8'(j), 64'(i * 'h1000 + j * 'h40)});
    repeat (30) step();
    mem_en = 1;
    repeat (90) step();

    arready_pct = 0;
    rq[1].push_back({8'd2, 64'h5000});
    repeat (6) step();
    arready_pct = 100;
    repeat (10) step();

    rq[2].push_back({8'd3, 64'h6000});
    rready_pct = 50;
    repeat (20) step();

    req_pct = 30; arready_pct = 60; rvalid_pct = 70; rready_pct = 60;
    repeat (3000) step();

    req_pct = 0; arready_pct = 100; rvalid_pct = 100; rready_pct = 100;
    repeat (300) step();
    chk("ar_drained", 32'(exp_ar.size()), 0);
    for (int i = 0; i < NREQ; i++) chk("r_drained", 32'(exp_r[i].size()), 0);

    mem_q.push_back({2'b00, 8'd7, 8'd0});
    repeat (4) step();
    do_reset();

    force_resp = 2'b10;
    rq[2].push_back({8'd3, 64'h2000});
    repeat (12) step();
    force_resp = 2'b00;
    do_reset();

    mem_q.push_back({2'b00, 8'd1, 8'd0});
    repeat (4) step();

    arready_pct = 0;
    rq[0].push_back({8'd1, 64'h3000});
    repeat (3) step();
    do_reset();
    arready_pct = 100;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
